// File: rtl/ksa_multiword_seq_pkg.sv
// Shared constants and FSM encoding for the sequential multi-word adder.
package ksa_multiword_seq_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ksa_multiword_seq_ksa.sv
// 8-bit Kogge-Stone adder: log2 prefix tree over generate/propagate pairs.
module KSA
  import ksa_multiword_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] A,
  input  logic [SLICE_W-1:0] B,
  input  logic               Cin,
  output logic [SLICE_W-1:0] Sum,
  output logic               Cout
);

  localparam int LVL = $clog2(SLICE_W);

  logic [SLICE_W-1:0] g_cur, p_cur, g_nxt, p_nxt;
  logic [SLICE_W:0]   carry;

  always_comb begin
    g_cur = A & B;
    p_cur = A ^ B;
    g_nxt = '0;
    p_nxt = '0;
    for (int l = 0; l < LVL; l++) begin
      for (int i = 0; i < SLICE_W; i++) begin
        if (i >= (1 << l)) begin
          g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i - (1 << l)]);
          p_nxt[i] = p_cur[i] & p_cur[i - (1 << l)];
        end else begin
          g_nxt[i] = g_cur[i];
          p_nxt[i] = p_cur[i];
        end
      end
      g_cur = g_nxt;
      p_cur = p_nxt;
    end
    // Group (g,p) over bits [i:0] folds in the slice carry-in.
    carry[0] = Cin;
    for (int i = 0; i < SLICE_W; i++) begin
      carry[i+1] = g_cur[i] | (p_cur[i] & Cin);
    end
  end

  assign Sum  = (A ^ B) ^ carry[SLICE_W-1:0];
  assign Cout = carry[SLICE_W];

endmodule

// File: rtl/ksa_multiword_seq.sv
// Multi-word add/subtract: one 8-bit KSA slice per clock, LSB first, carry kept in a register.
module ksa_multiword_seq
  import ksa_multiword_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SLICE_W*WORDS-1:0]   A,
  input  logic [SLICE_W*WORDS-1:0]   B,
  input  logic                       Cin,
  input  logic                       sub,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SLICE_W*WORDS-1:0]   Sum,
  output logic                       Cout,
  output logic                       Ovf
);

  localparam int W     = SLICE_W * WORDS;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid
  // never depends on ready, and in_ready only follows out_ready while in DONE.

  state_t           state, state_n;
  logic [W-1:0]     a_q, b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;
  logic [SLICE_W-1:0] a_slice, b_slice, ksa_sum;
  logic             ksa_cout;
  logic             accept, last;

  assign accept = in_valid && in_ready;
  assign last   = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = BUSY;
      BUSY:    if (last) state_n = DONE;
      DONE:    if (out_ready) state_n = in_valid ? BUSY : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE:    in_ready = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  assign a_slice = a_q[idx*SLICE_W +: SLICE_W];
  assign b_slice = b_q[idx*SLICE_W +: SLICE_W];

  KSA u_ksa (
    .A    (a_slice),
    .B    (b_slice),
    .Cin  (carry_q),
    .Sum  (ksa_sum),
    .Cout (ksa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      Sum     <= '0;
      Cout    <= 1'b0;
      Ovf     <= 1'b0;
    end else if (accept) begin
      a_q     <= A;
      b_q     <= sub ? ~B : B;
      carry_q <= sub ? 1'b1 : Cin;
      idx     <= '0;
      Sum     <= '0;
    end else if (state == BUSY) begin
      Sum[idx*SLICE_W +: SLICE_W] <= ksa_sum;
      carry_q <= ksa_cout;
      if (last) begin
        Cout <= ksa_cout;
        // b_q already holds the inverted operand when subtracting.
        Ovf  <= (a_q[W-1] == b_q[W-1]) && (ksa_sum[SLICE_W-1] != a_q[W-1]);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ksa_multiword_seq.sv
// Bench for ksa_multiword_seq: directed corner cases, backpressure, reset abort, random traffic.
module tb_ksa_multiword_seq;
  import ksa_multiword_seq_pkg::*;

  localparam int WORDS = 4;
  localparam int W     = SLICE_W * WORDS;

  logic         clk, rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] A, B, Sum;
  logic         Cin, sub, Cout, Ovf;

  logic [W+1:0] exp_q[$];
  int           n_vec  = 0;
  int           n_miss = 0;
  logic         rnd_on = 1'b0;

  ksa_multiword_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Returns {sum, cout, ovf} from integer arithmetic on the full-width values.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci, input logic sb);
    longint ua, ub, ures, sa, sbv, sres;
    logic [W-1:0] s;
    logic co, ov;
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (sb) begin
      ures = ua - ub + (64'sd1 <<< W);
      sres = sa - sbv;
    end else begin
      ures = ua + ub + longint'(ci);
      sres = sa + sbv + longint'(ci);
    end
    s  = ures[W-1:0];
    co = ures[W];
    ov = (sres > ((64'sd1 <<< (W-1)) - 1)) || (sres < -(64'sd1 <<< (W-1)));
    return {s, co, ov};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_result");
        else check("result", 64'({Sum, Cout, Ovf}), 64'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) exp_q.push_back(model(A, B, Cin, sub));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic sb);
    int n = 0;
    @(posedge clk); #1;
    A = a; B = b; Cin = ci; sub = sb; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) fail_now("accept_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom; Cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!out_valid && cyc < 50);
    if (!out_valid) fail_now("result_timeout");
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] specials[4];
    specials[0] = '0;
    specials[1] = '1;
    specials[2] = {1'b1, {(W-1){1'b0}}};
    specials[3] = {1'b0, {(W-1){1'b1}}};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_on) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- stimulus ----------------
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sb;
  } vec_t;

  initial begin
    vec_t dir[5];
    int   cyc;
    logic [W-1:0] ra, rb;

    dir[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
    dir[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
    dir[2] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0};
    dir[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1};
    dir[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1};

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum",       64'(Sum),       64'd0);
    check("rst_cout_ovf",  64'({Cout, Ovf}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Directed corners with exact latency
    for (int i = 0; i < 5; i++) begin
      issue(dir[i].a, dir[i].b, dir[i].ci, dir[i].sb);
      wait_result(cyc);
      check("latency", 64'(cyc), 64'(WORDS));
    end
    @(posedge clk); #1;

    // Backpressure hold, then consume and accept on the same edge
    out_ready = 1'b0;
    issue(32'hA5A5_0F0F, 32'h5A5A_F0F1, 1'b0, 1'b0);
    wait_result(cyc);
    check("bp_latency", 64'(cyc), 64'(WORDS));
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_hold", 64'({Sum, Cout, Ovf}), 64'(model(32'hA5A5_0F0F, 32'h5A5A_F0F1, 1'b0, 1'b0)));
      check("bp_in_ready",  64'(in_ready),  64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D; Cin = 1'b0; sub = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("chain_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(cyc);
    check("chain_latency", 64'(cyc), 64'(WORDS));
    @(posedge clk); #1;

    // Reset two cycles into an operation
    issue(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_sum",       64'(Sum),       64'd0);
    check("abort_in_ready",  64'(in_ready),  64'd1);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", 64'({in_ready, out_valid}), 64'b10);
    issue(32'h1357_9BDF, 32'h2468_ACE0, 1'b1, 1'b0);
    wait_result(cyc);
    check("post_rst_latency", 64'(cyc), 64'(WORDS));
    @(posedge clk); #1;

    // Random traffic with random consumer stalls
    rnd_on = 1'b1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      ra = pick_operand();
      rb = pick_operand();
      issue(ra, rb, 1'($urandom), 1'($urandom));
    end
    rnd_on = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
        @(posedge clk);
        n++;
      end
    end
    @(posedge clk); #1;
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ksa_multiword_seq.md
Name: ksa_multiword_seq

Overview:
- Sequential multi-word adder/subtractor built around the existing 8-bit Kogge-Stone adder (module KSA).
- Accepts wide operands over a valid/ready handshake and processes one 8-bit slice per clock, LSB slice first.
- Carries between slices through a register and returns the wide sum, carry-out and signed-overflow flag over a second valid/ready handshake.
- Sits between the operand-issue logic and the result consumer. It is the sequencing stage that feeds the 8-bit adder and consumes its output.

Parameters:
- WORDS, 4, number of 8-bit slices; operand width W = 8*WORDS; legal range 2..16.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept operands
- A  in  W  operand A
- B  in  W  operand B
- Cin  in  1  carry-in (add mode only)
- sub  in  1  1 = compute A - B
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- Sum  out  W  result
- Cout  out  1  carry-out of MSB slice (add: carry; sub: 1 = no borrow)
- Ovf  out  1  two's-complement overflow

Behaviour:
- Reset: one clock, asynchronous active-low reset.
  - While rst_n=0: state=IDLE, in_ready=1, out_valid=0, Sum=0, Cout=0, Ovf=0.
  - Internal operand, carry and index registers are cleared.
- Accept: an operation is accepted on a rising edge where in_valid && in_ready.
  - Latch A into A_q.
  - Latch Beff = sub ? ~B : B into B_q.
  - Set carry_q = sub ? 1 : Cin.
  - Set idx = 0 and clear Sum.
- States:
  - IDLE: in_ready=1, out_valid=0. Accept goes to BUSY.
  - BUSY: in_ready=0, out_valid=0. Each cycle the KSA is driven with A_q/B_q slice idx and carry_q.
    - The KSA sum is written to Sum[8*idx+7:8*idx].
    - carry_q takes the KSA Cout and idx increments.
    - When idx==WORDS-1 the slice is written, Cout takes the slice carry, Ovf is computed, and the state goes to DONE.
  - DONE: out_valid=1, and Sum/Cout/Ovf are held stable.
    - On out_ready=1 the result is consumed.
    - If in_valid=1 in the same cycle, the new operands are accepted and the state goes to BUSY.
    - Otherwise the state goes to IDLE.
    - In DONE, in_ready = out_ready (combinational).
- Latency: out_valid rises exactly WORDS cycles after the accepting edge. Throughput with back-to-back traffic is one operation per WORDS+1 cycles.
- Ovf = (A_q[W-1] == B_q[W-1]) && (Sum[W-1] != A_q[W-1]), using the effective (possibly inverted) B.
- Cin is ignored when sub=1.
- Inputs are sampled only at the accepting edge. Changes to A/B/Cin/sub while in BUSY or DONE have no effect.
- out_ready while not in DONE is ignored. in_valid while in_ready=0 is not accepted and does not need to be held.
- Partial Sum is visible during BUSY but is not qualified; consumers use out_valid only.
- Reset asserted mid-BUSY or mid-DONE aborts the operation immediately. No result is produced, and the block is in IDLE on the first edge after rst_n rises.
- Wrap-around: the width-W sum wraps modulo 2^W, and the carry is reported only on Cout.

Decomposition:
- Shared package: constant SLICE_W=8 and a state enumeration {IDLE, BUSY, DONE} (2-bit encoding).
- Sub-module: one instance of the existing KSA (8-bit A/B/Cin to Sum/Cout) as the only arithmetic element.
- Slice mux and carry/index registers stay in ksa_multiword_seq.
- No second sub-module.

Test Plan (WORDS=4):
- Add with full carry ripple: A=0xFFFF_FFFF, B=0x0000_0001, Cin=0, sub=0 -> Sum=0x0000_0000, Cout=1, Ovf=0; out_valid exactly 4 cycles after accept.
- Signed overflow: A=0x7FFF_FFFF, B=0x0000_0001, Cin=0 -> Sum=0x8000_0000, Cout=0, Ovf=1.
- Add with carry-in: A=0x1234_5678, B=0x1111_1111, Cin=1 -> Sum=0x2345_678A, Cout=0, Ovf=0.
- Subtract with borrow: A=0x0000_0005, B=0x0000_0007, sub=1, Cin=1 (ignored) -> Sum=0xFFFF_FFFE, Cout=0, Ovf=0.
  - Also A=0x8000_0000 minus B=1 -> Sum=0x7FFF_FFFF, Cout=1, Ovf=1.
- Backpressure and chaining:
  - Hold out_ready=0 for 10 cycles in DONE -> Sum/Cout/Ovf stable, in_ready=0.
  - Then assert out_ready=1 and in_valid=1 together -> result consumed and new operation accepted on the same edge; next out_valid 4 cycles later.
- Reset mid-operation: assert rst_n=0 two cycles after accept -> out_valid=0, Sum=0 and in_ready=1 immediately, no result emitted.
  - A new operation after reset release completes normally with correct Sum.
